// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART peripherals.
package uart_pkg;

  // Transmitter state encoding, shared with any later RX/debug logic.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } tx_state_t;

  localparam int          UART_DATA_BITS  = 8;
  localparam logic [31:0] TX_ADDR_DEFAULT = 32'h0000_00FC;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory write port exported by the MIPS datapath.
interface mmio_uart_tx_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output mem_write, output addr, output wdata);
  modport slave  (input  mem_write, input  addr, input  wdata);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, depth 2**AW. A push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,      // asynchronous, active-low
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,     // head entry, valid while !o_empty
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_push_ok
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH);
  assign o_count   = r_count;
  assign w_pop     = i_pop & ~o_empty;
  assign w_push    = i_push & (~o_full | w_pop);
  assign o_push_ok = w_push;
  // Head is read combinationally so the consumer can load it on the pop edge.
  assign o_dout    = r_mem[r_rd_ptr];

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally modulo depth; count is unchanged on push+pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-word to TX_ADDR queues a byte; FIFO drains as 8N1
// frames, LSB first. Optional macro PARITY_EN adds an even-parity bit (8E1).
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = TX_ADDR_DEFAULT,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_AW      = 4
) (
  input  logic                 clk,
  input  logic                 reset,     // asynchronous, active-low
  mmio_uart_tx_if.slave        bus,
  output logic                 serial,
  output logic                 tx_busy,
  output logic                 fifo_full,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_STOP   = STOP;
`ifdef PARITY_EN
  localparam logic [2:0] ST_PARITY = PARITY;
  logic                  r_parity;
`endif

  logic [2:0]        r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_serial;
  logic              r_overflow;

  logic              w_push_req;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_baud_last;
  logic              w_empty;
  logic [7:0]        w_fifo_dout;
  logic              w_unused_wdata;

  // Only the low byte of the store is transmitted.
  assign w_unused_wdata = ^bus.wdata[31:8];

  assign w_push_req  = bus.mem_write & (bus.addr == TX_ADDR);
  assign w_baud_last = (r_baud == BAUD_LAST);
  // Load a new byte from IDLE, or on the final STOP cycle for gapless frames.
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                             ((r_state == ST_STOP) & w_baud_last));

  sync_fifo #(.AW(FIFO_AW), .DW(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push_req),
    .i_pop     (w_pop),
    .i_din     (bus.wdata[7:0]),
    .o_dout    (w_fifo_dout),
    .o_count   (fifo_count),
    .o_full    (fifo_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok)
  );

  assign serial   = r_serial;
  assign tx_busy  = (r_state != ST_IDLE) | ~w_empty;
  assign overflow = r_overflow;

  // Sticky overflow: a matching store that the FIFO could not take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      r_overflow <= 1'b0;
    else if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
  end

  // Frame FSM; serial is registered with the value of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_serial  <= 1'b1;
`ifdef PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift  <= w_fifo_dout;
`ifdef PARITY_EN
            r_parity <= ^w_fifo_dout;
`endif
            r_state  <= ST_START;
            r_serial <= 1'b0;
          end
        end
        ST_START: begin
          if (w_baud_last) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
            r_serial  <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (r_bit_idx == LAST_BIT) begin
`ifdef PARITY_EN
              r_state  <= ST_PARITY;
              r_serial <= r_parity;
`else
              r_state  <= ST_STOP;
              r_serial <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_serial  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef PARITY_EN
        ST_PARITY: begin
          if (w_baud_last) begin
            r_baud   <= '0;
            r_state  <= ST_STOP;
            r_serial <= 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_baud_last) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift  <= w_fifo_dout;
`ifdef PARITY_EN
              r_parity <= ^w_fifo_dout;
`endif
              r_state  <= ST_START;
              r_serial <= 1'b0;
            end else begin
              r_state  <= ST_IDLE;
              r_serial <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_baud   <= '0;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stores with a scoreboard of expected bytes and a
// serial-line monitor that decodes frames and checks them against it.
module tb_mmio_uart_tx;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          serial;
  logic          tx_busy;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int            n_vec  = 0;
  int            n_miss = 0;
  int unsigned   cyc    = 0;
  logic [7:0]    sb[$];
  int unsigned   starts[$];
  logic          last_par = 1'b0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .TX_ADDR      (32'h0000_00FC),
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset_n),
    .bus        (bus),
    .serial     (serial),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Drive the write port at the next falling edge; it is sampled on the rise.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mem_write = w;
    bus.addr      = a;
    bus.wdata     = d;
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (tx_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy) chk("wait_idle_timeout", 32'(tx_busy), 32'd0);
  endtask

  task automatic wait_cycles(input int n, output bit abort);
    abort = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!reset_n) begin
        abort = 1'b1;
        return;
      end
    end
  endtask

  // Monitor: decode each frame mid-bit and compare with the scoreboard head.
  initial begin : monitor
    logic [7:0] d;
    logic [7:0] exp_b;
    logic       par;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!reset_n || serial !== 1'b0) continue;
      starts.push_back(cyc);
      wait_cycles(2, ab);
      if (ab) continue;
      chk("start_bit", 32'(serial), 32'd0);
      for (int i = 0; i < 8; i++) begin
        wait_cycles(CPB, ab);
        if (ab) break;
        d[i] = serial;
      end
      if (ab) continue;
      par = 1'b0;
`ifdef PARITY_EN
      wait_cycles(CPB, ab);
      if (ab) continue;
      par = serial;
      last_par = par;
`endif
      wait_cycles(CPB, ab);
      if (ab) continue;
      chk("stop_bit", 32'(serial), 32'd1);
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL frame_unexpected: got %0h required no frame", d);
      end else begin
        exp_b = sb.pop_front();
        chk("frame_data", 32'(d), 32'(exp_b));
`ifdef PARITY_EN
        chk("frame_parity", 32'(par), 32'(^exp_b));
`endif
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    logic [7:0] b4 [6];
    b4 = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'hF0, 8'h0F};

    reset_n = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(serial), 32'd1);
    chk("rst_busy",   32'(tx_busy), 32'd0);
    chk("rst_full",   32'(fifo_full), 32'd0);
    chk("rst_count",  32'(fifo_count), 32'd0);
    chk("rst_ovf",    32'(overflow), 32'd0);
    reset_n = 1'b1;

    // 1: single frame, latency and length
    sb.push_back(8'h55);
    drive(1'b1, 32'h0000_00FC, 32'h1234_5655);
    drive(1'b0, 32'h0, 32'h0);
    chk("t1_count_after_push", 32'(fifo_count), 32'd1);
    chk("t1_serial_idle",      32'(serial), 32'd1);
    @(negedge clk);
    chk("t1_serial_start",     32'(serial), 32'd0);
    chk("t1_count_popped",     32'(fifo_count), 32'd0);
    wait_idle(FRAME + 20, n);
    chk("t1_frame_len", 32'(n), 32'(FRAME));
    chk("t1_sb_drained", 32'(sb.size()), 32'd0);

    // 2: wrong address and mem_write=0 are ignored
    drive(1'b1, 32'h0000_00F8, 32'h0000_00A5);
    drive(1'b0, 32'h0000_00FC, 32'h0000_00A5);
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      chk("t2_count", 32'(fifo_count), 32'd0);
      chk("t2_serial", 32'(serial), 32'd1);
      @(negedge clk);
    end
    chk("t2_busy", 32'(tx_busy), 32'd0);
    chk("t2_ovf",  32'(overflow), 32'd0);

    // 3: six back-to-back stores, sixth dropped
    starts.delete();
    for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
    for (int i = 1; i <= 6; i++) drive(1'b1, 32'h0000_00FC, 32'hABCD_EF00 | 32'(i));
    drive(1'b0, 32'h0, 32'h0);
    chk("t3_count", 32'(fifo_count), 32'd4);
    chk("t3_full",  32'(fifo_full), 32'd1);
    chk("t3_ovf",   32'(overflow), 32'd1);
    wait_idle(5 * FRAME + 20, n);
    chk("t3_sb_drained", 32'(sb.size()), 32'd0);
    chk("t3_frames", 32'(starts.size()), 32'd5);
    for (int k = 1; k < starts.size(); k++)
      chk("t3_frame_gap", starts[k] - starts[k-1], 32'(FRAME));

    // 4: push while full on the last STOP cycle is accepted
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back(b4[i]);
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h0000_00FC, 32'(b4[i]));
    drive(1'b0, 32'h0, 32'h0);
    repeat (FRAME - 5) @(negedge clk);
    chk("t4_count_before", 32'(fifo_count), 32'd4);
    chk("t4_full_before",  32'(fifo_full), 32'd1);
    drive(1'b1, 32'h0000_00FC, 32'(b4[5]));
    drive(1'b0, 32'h0, 32'h0);
    chk("t4_count_same", 32'(fifo_count), 32'd4);
    chk("t4_no_ovf",     32'(overflow), 32'd0);
    chk("t4_next_start", 32'(serial), 32'd0);
    wait_idle(6 * FRAME + 20, n);
    chk("t4_sb_drained", 32'(sb.size()), 32'd0);

    // 5: reset in the middle of DATA aborts, then a clean frame
    sb.push_back(8'h96);
    sb.push_back(8'hA1);
    sb.push_back(8'hB2);
    drive(1'b1, 32'h0000_00FC, 32'h96);
    drive(1'b1, 32'h0000_00FC, 32'hA1);
    drive(1'b1, 32'h0000_00FC, 32'hB2);
    drive(1'b0, 32'h0, 32'h0);
    chk("t5_count_pre", 32'(fifo_count), 32'd2);
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("t5_rst_serial", 32'(serial), 32'd1);
    chk("t5_rst_count",  32'(fifo_count), 32'd0);
    chk("t5_rst_busy",   32'(tx_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(8'h5A);
    drive(1'b1, 32'h0000_00FC, 32'h5A);
    drive(1'b0, 32'h0, 32'h0);
    wait_idle(FRAME + 20, n);
    chk("t5_frame_len", 32'(n), 32'(FRAME + 1));
    chk("t5_sb_drained", 32'(sb.size()), 32'd0);

`ifdef PARITY_EN
    // 6: parity bit for 8'h07 is 1, frame is 44 cycles
    sb.push_back(8'h07);
    drive(1'b1, 32'h0000_00FC, 32'h07);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    wait_idle(FRAME + 20, n);
    chk("t6_frame_len", 32'(n), 32'd44);
    chk("t6_parity",    32'(last_par), 32'd1);
    chk("t6_sb_drained", 32'(sb.size()), 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmit peripheral placed directly downstream of the single-cycle MIPS datapath. It consumes the datapath's exported data-memory write port (MemWrite, ALU address, RD2 write data). A store word to TX_ADDR pushes the low byte into a transmit FIFO. The FIFO drains onto the serial line as 8N1 frames, LSB first.

Parameters:
TX_ADDR, 32'h0000_00FC, byte address that triggers a push (full 32-bit compare)
CLKS_PER_BIT, 434, clk cycles per serial bit; legal range >= 2
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_write  in  1  datapath MemWrite
addr  in  32  datapath ALU result (data memory address)
wdata  in  32  datapath register-file RD2 (store data)
serial  out  1  UART TX line, idle high
tx_busy  out  1  high whenever the FSM is not IDLE or the FIFO is non-empty
fifo_full  out  1  FIFO holds 2**FIFO_AW entries
fifo_count  out  FIFO_AW+1  current occupancy
overflow  out  1  sticky; set when a push is dropped

Behaviour:
- Reset (reset=0, async) forces serial=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE, and clears the pointers and baud counter. Asserting reset mid-frame aborts the frame immediately: serial goes high and the FIFO contents are discarded.
- Push: on a clk edge with mem_write=1 and addr==TX_ADDR, wdata[7:0] is written. wdata[31:8] is ignored.
- Accept rule: the push is accepted if fifo_count < depth, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set. overflow clears only on reset.
- Pop: occurs when the FSM loads a byte, either in IDLE with the FIFO non-empty or at the last STOP cycle with the FIFO non-empty.
- Simultaneous push and pop: fifo_count is unchanged; pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial=1. If the FIFO is non-empty, pop into the shift register and go to START at the next edge.
  - START: serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: serial=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit 7, go to STOP.
  - STOP: serial=1 for CLKS_PER_BIT cycles. On the last cycle, go to START (back-to-back, with a pop) if the FIFO is non-empty, else go to IDLE.
- Latency: a push to an empty FIFO with FSM=IDLE at edge N makes fifo_count=1 after N. The FSM pops at edge N+1, and serial falls to 0 after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles, with no idle gap between back-to-back frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets on every state/bit transition. Its width is $clog2(CLKS_PER_BIT).
- Non-matching addresses and mem_write=0 have no effect.
- serial is driven from a flop (glitch-free).

Optional Feature:
PARITY_EN
- Defined: an even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles. Frame length is 11*CLKS_PER_BIT.
- Undefined: there is no PARITY state and frames are 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP, PARITY)
  - the constant UART_DATA_BITS=8
  - the default TX_ADDR constant
- Sub-module sync_fifo (parameter AW, width 8) handles push/pop/count/full/empty and the same-cycle push-pop rule. It is reusable for a later RX path.
- mmio_uart_tx contains the address decode, the FSM, the baud counter and the shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_AW=2):
1. Reset, then store 32'h1234_5655 to 32'hFC. serial falls one edge after the push and shows bits 0,1,0,1,0,1,0,1,0,1 (start, 8'h55 LSB first, stop), 4 cycles each. tx_busy then drops.
2. Store 8'hA5 to 32'hF8, and separately set mem_write=0 with addr=32'hFC. serial stays 1, fifo_count stays 0.
3. Six consecutive stores (8'h01..8'h06) while the first frame is active. Bytes 01..05 are accepted (first popped, 4 buffered), byte 06 is dropped and overflow=1. The line shows 01..05 back-to-back with no idle between frames (40 cycles per frame).
4. FIFO full while STOP is in its last cycle, with a push in the same cycle. The push is accepted and fifo_count stays 4.
5. Drop reset to 0 in the middle of DATA. serial=1 and fifo_count=0 immediately. After release, a new store transmits cleanly.
6. With PARITY_EN defined, send 8'h07. The parity bit is 1 and the frame is 44 cycles.
